// File: rtl/parking_meter_core.sv
// ----------------------------------------------------------------------------
// parking_meter_core
//
// Timekeeping core for a multi-space parking meter. Keeps NUM_METERS
// independent 14-bit second counters. The selected meter can have time added
// or preset, and every meter counts down on the 1 Hz tick. The selected
// meter's value is converted to 4-digit BCD by a sequential double-dabble
// engine, and blink/blank control is produced for the display.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   tick_1hz   one-cycle pulse at 1 Hz, decrements every non-zero meter
//   tick_2hz   one-cycle pulse at 2 Hz, toggles the expired blink phase
//   sel        meter addressed by add/load and shown on the display
//   add_req    one-cycle add pulses, lowest set bit wins
//   load_a     one-cycle preset of the selected meter to LOAD_A
//   load_b     one-cycle preset of the selected meter to LOAD_B
//   time_bcd   {d3,d2,d1,d0} BCD of the selected meter
//   bcd_valid  time_bcd matches the current selected value
//   disp_on    0 = blank the display this cycle
//   mode       00 normal, 01 low, 10 expired (selected meter)
//   expired    per-meter flag, set while the meter value is 0
// ----------------------------------------------------------------------------
module parking_meter_core #(
   parameter int NUM_METERS  = 2,
   parameter int SEL_W       = 1,
   parameter int MAX_SECONDS = 9999,
   parameter int ADD0        = 60,
   parameter int ADD1        = 120,
   parameter int ADD2        = 180,
   parameter int ADD3        = 300,
   parameter int LOAD_A      = 15,
   parameter int LOAD_B      = 150,
   parameter int LOW_THRESH  = 180
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick_1hz,
   input  logic                  tick_2hz,
   input  logic [SEL_W-1:0]      sel,
   input  logic [3:0]            add_req,
   input  logic                  load_a,
   input  logic                  load_b,
   output logic [15:0]           time_bcd,
   output logic                  bcd_valid,
   output logic                  disp_on,
   output logic [1:0]            mode,
   output logic [NUM_METERS-1:0] expired
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } conv_state_t;

   logic              sel_in_range;
   logic [SEL_W-1:0]  disp_idx;
   logic [14:0]       add_amt;
   logic              add_any;
   logic [13:0]       meter_val [NUM_METERS];
   logic [13:0]       sel_val;

   logic              blink_phase_q, blink_phase_d;

   conv_state_t       state_q, state_d;
   logic              snap_valid_q, snap_valid_d;
   logic [13:0]       snap_val_q, snap_val_d;
   logic [SEL_W-1:0]  snap_sel_q, snap_sel_d;
   logic [29:0]       shreg_q, shreg_d;
   logic [3:0]        iter_q, iter_d;
   logic [15:0]       time_bcd_q, time_bcd_d;
   logic              bcd_valid_q, bcd_valid_d;
   logic [29:0]       dd_adj;

   // Out-of-range selects address no meter for add/load and fall back to
   // meter 0 for the display path.
   always_comb begin
      sel_in_range = (int'(sel) < NUM_METERS);
      disp_idx     = sel_in_range ? sel : '0;
   end

   // Add amount from the lowest set add_req bit, widened to 15 bits so the
   // sum can exceed the 14-bit counter before saturation.
   always_comb begin
      add_amt = '0;
      add_any = |add_req;
      if (add_req[0]) begin
         add_amt = 15'(ADD0);
      end else if (add_req[1]) begin
         add_amt = 15'(ADD1);
      end else if (add_req[2]) begin
         add_amt = 15'(ADD2);
      end else if (add_req[3]) begin
         add_amt = 15'(ADD3);
      end
   end

   // One counter per meter. The decrement is folded into the add path so a
   // tick and an add in the same cycle both take effect; loads override the
   // tick entirely.
   for (genvar g = 0; g < NUM_METERS; g++) begin : g_meter
      logic [13:0] val_q, val_d;
      logic [13:0] dec_val;
      logic [14:0] sum;
      logic        hit;
      logic        dec;

      always_comb begin
         hit     = sel_in_range && (int'(sel) == g);
         dec     = tick_1hz && (val_q != 14'd0);
         dec_val = val_q - {13'd0, dec};
         sum     = {1'b0, dec_val} + add_amt;
         val_d   = dec_val;
         if (hit && load_b) begin
            val_d = 14'(LOAD_B);
         end else if (hit && load_a) begin
            val_d = 14'(LOAD_A);
         end else if (hit && add_any) begin
            val_d = (sum > 15'(MAX_SECONDS)) ? 14'(MAX_SECONDS) : sum[13:0];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            val_q <= '0;
         end else begin
            val_q <= val_d;
         end
      end

      assign meter_val[g] = val_q;
      assign expired[g]   = (val_q == 14'd0);
   end

   assign sel_val = meter_val[disp_idx];

   // Expired meters blink at the 2 Hz phase; it starts in the "on" phase.
   always_comb begin
      blink_phase_d = blink_phase_q ^ tick_2hz;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_phase_q <= 1'b1;
      end else begin
         blink_phase_q <= blink_phase_d;
      end
   end

   // Display mode of the selected meter. In low mode the LSB of the seconds
   // value gives a 1 s on / 1 s off blink without extra state.
   always_comb begin
      mode    = 2'b00;
      disp_on = 1'b1;
      if (sel_val == 14'd0) begin
         mode    = 2'b10;
         disp_on = blink_phase_q;
      end else if (sel_val < 14'(LOW_THRESH)) begin
         mode    = 2'b01;
         disp_on = sel_val[0];
      end
   end

   // One double-dabble step on {bcd[15:0], bin[13:0]}: add 3 to every BCD
   // nibble >= 5, the caller then shifts the whole register left by one.
   always_comb begin
      dd_adj = shreg_q;
      for (int j = 0; j < 4; j++) begin
         if (shreg_q[14 + 4*j +: 4] >= 4'd5) begin
            dd_adj[14 + 4*j +: 4] = shreg_q[14 + 4*j +: 4] + 4'd3;
         end
      end
   end

   // Converter FSM. A snapshot of the selected value and sel is taken when a
   // conversion starts; the snapshot-valid flag forces a first conversion
   // after reset. time_bcd only changes in DONE so no partial result is seen.
   always_comb begin
      state_d      = state_q;
      snap_valid_d = snap_valid_q;
      snap_val_d   = snap_val_q;
      snap_sel_d   = snap_sel_q;
      shreg_d      = shreg_q;
      iter_d       = iter_q;
      time_bcd_d   = time_bcd_q;
      bcd_valid_d  = bcd_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (!snap_valid_q || (sel_val != snap_val_q) || (sel != snap_sel_q)) begin
               snap_valid_d = 1'b1;
               snap_val_d   = sel_val;
               snap_sel_d   = sel;
               shreg_d      = {16'd0, sel_val};
               iter_d       = 4'd0;
               bcd_valid_d  = 1'b0;
               state_d      = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shreg_d = {dd_adj[28:0], 1'b0};
            iter_d  = iter_q + 4'd1;
            if (iter_q == 4'd13) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            time_bcd_d  = shreg_q[29:14];
            bcd_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         snap_valid_q <= 1'b0;
         snap_val_q   <= '0;
         snap_sel_q   <= '0;
         shreg_q      <= '0;
         iter_q       <= '0;
         time_bcd_q   <= 16'h0000;
         bcd_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         snap_valid_q <= snap_valid_d;
         snap_val_q   <= snap_val_d;
         snap_sel_q   <= snap_sel_d;
         shreg_q      <= shreg_d;
         iter_q       <= iter_d;
         time_bcd_q   <= time_bcd_d;
         bcd_valid_q  <= bcd_valid_d;
      end
   end

   assign time_bcd  = time_bcd_q;
   assign bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_parking_meter_core.sv
// ----------------------------------------------------------------------------
// tb_parking_meter_core
//
// Scoreboard bench for parking_meter_core. The driver applies one cycle of
// inputs at a time, pushes the expected outputs from a behavioural model into
// a queue, and a separate monitor pops and compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_parking_meter_core;

   localparam int NUM_METERS  = 2;
   localparam int SEL_W       = 1;
   localparam int MAX_SECONDS = 9999;
   localparam int LOAD_A      = 15;
   localparam int LOAD_B      = 150;
   localparam int LOW_THRESH  = 180;

   logic                  clk;
   logic                  rst;
   logic                  tick1;
   logic                  tick2;
   logic [SEL_W-1:0]      sel;
   logic [3:0]            addReq;
   logic                  loadA;
   logic                  loadB;
   logic [15:0]           timeBcd;
   logic                  bcdValid;
   logic                  dispOn;
   logic [1:0]            mode;
   logic [NUM_METERS-1:0] expired;

   typedef struct packed {
      logic [1:0]            mode;
      logic                  dispOn;
      logic [NUM_METERS-1:0] expired;
      logic [15:0]           bcd;
      logic                  valid;
   } exp_t;

   exp_t expQ[$];

   int totalCnt;
   int badCnt;

   // Behavioural model state
   int          mVal[NUM_METERS];
   bit          mBlink;
   bit          mReady;
   int          mEdge;
   bit          mBusy;
   int          mDoneAt;
   bit          mSnapValid;
   int          mSnapVal;
   int          mSnapSel;
   logic [15:0] mBcd;
   bit          mValid;
   int          curSel;

   parking_meter_core #(
      .NUM_METERS (NUM_METERS),
      .SEL_W      (SEL_W),
      .MAX_SECONDS(MAX_SECONDS),
      .ADD0       (60),
      .ADD1       (120),
      .ADD2       (180),
      .ADD3       (300),
      .LOAD_A     (LOAD_A),
      .LOAD_B     (LOAD_B),
      .LOW_THRESH (LOW_THRESH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick_1hz (tick1),
      .tick_2hz (tick2),
      .sel      (sel),
      .add_req  (addReq),
      .load_a   (loadA),
      .load_b   (loadB),
      .time_bcd (timeBcd),
      .bcd_valid(bcdValid),
      .disp_on  (dispOn),
      .mode     (mode),
      .expired  (expired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int addFor(input logic [3:0] a);
      if (a[0]) return 60;
      if (a[1]) return 120;
      if (a[2]) return 180;
      if (a[3]) return 300;
      return 0;
   endfunction

   function automatic logic [15:0] toBcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Expected combinational/registered outputs for the current model state
   // with the given select input.
   function automatic exp_t expectedNow(input int s);
      exp_t e;
      int   v;
      v = mVal[(s < NUM_METERS) ? s : 0];
      e.bcd   = mBcd;
      e.valid = mValid;
      for (int i = 0; i < NUM_METERS; i++) begin
         e.expired[i] = (mVal[i] == 0);
      end
      if (v == 0) begin
         e.mode   = 2'b10;
         e.dispOn = mBlink;
      end else if (v < LOW_THRESH) begin
         e.mode   = 2'b01;
         e.dispOn = v[0];
      end else begin
         e.mode   = 2'b00;
         e.dispOn = 1'b1;
      end
      return e;
   endfunction

   // Advance the model across one clock edge with the inputs seen there.
   // The converter takes a snapshot when idle and the shown value or sel has
   // moved, and publishes the BCD result 15 edges after the snapshot edge.
   task automatic modelStep(input bit r, input bit t1, input bit t2, input int s,
                            input logic [3:0] a, input bit la, input bit lb);
      int selv;
      int nv;
      mEdge++;
      if (r) begin
         for (int i = 0; i < NUM_METERS; i++) mVal[i] = 0;
         mBlink     = 1'b1;
         mBusy      = 1'b0;
         mSnapValid = 1'b0;
         mBcd       = 16'h0000;
         mValid     = 1'b0;
         mReady     = 1'b1;
      end else begin
         selv = mVal[(s < NUM_METERS) ? s : 0];
         if (mBusy) begin
            if (mEdge == mDoneAt) begin
               mBcd   = toBcd(mSnapVal);
               mValid = 1'b1;
               mBusy  = 1'b0;
            end
         end else if (!mSnapValid || selv != mSnapVal || s != mSnapSel) begin
            mSnapValid = 1'b1;
            mSnapVal   = selv;
            mSnapSel   = s;
            mValid     = 1'b0;
            mBusy      = 1'b1;
            mDoneAt    = mEdge + 15;
         end
         for (int i = 0; i < NUM_METERS; i++) begin
            nv = (t1 && mVal[i] > 0) ? mVal[i] - 1 : mVal[i];
            if (i == s && lb) begin
               nv = LOAD_B;
            end else if (i == s && la) begin
               nv = LOAD_A;
            end else if (i == s && a != 4'b0000) begin
               nv = nv + addFor(a);
               if (nv > MAX_SECONDS) nv = MAX_SECONDS;
            end
            mVal[i] = nv;
         end
         mBlink = mBlink ^ t2;
      end
   endtask

   // Drive one cycle: set inputs, queue the expectation for the state now
   // visible, then cross the clock edge and advance the model.
   task automatic applyStimulus(input bit r, input bit t1, input bit t2, input int s,
                                input logic [3:0] a, input bit la, input bit lb);
      rst    = r;
      tick1  = t1;
      tick2  = t2;
      sel    = SEL_W'(s);
      addReq = a;
      loadA  = la;
      loadB  = lb;
      curSel = s;
      if (mReady) expQ.push_back(expectedNow(s));
      @(posedge clk);
      #1;
      modelStep(r, t1, t2, s, a, la, lb);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, curSel, 4'b0000, 1'b0, 1'b0);
   endtask

   task automatic checkField(input string name, input logic [15:0] got, input logic [15:0] want);
      totalCnt++;
      if (got !== want) begin
         badCnt++;
         $display("[TB] FAIL %s at %0t: got=%0h want=%0h", name, $time, got, want);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checkField("mode", 16'(mode), 16'(e.mode));
      checkField("disp_on", 16'(dispOn), 16'(e.dispOn));
      checkField("expired", 16'(expired), 16'(e.expired));
      checkField("bcd_valid", 16'(bcdValid), 16'(e.valid));
      checkField("time_bcd", timeBcd, e.bcd);
   endtask

   // Monitor: compare the DUT against queued expectations on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      totalCnt = 0;
      badCnt   = 0;
      mReady   = 1'b0;
      mEdge    = 0;
      mBusy    = 1'b0;
      mDoneAt  = 0;
      mSnapValid = 1'b0;
      mSnapVal = 0;
      mSnapSel = 0;
      mBcd     = 16'h0000;
      mValid   = 1'b0;
      mBlink   = 1'b1;
      curSel   = 0;
      for (int i = 0; i < NUM_METERS; i++) mVal[i] = 0;

      $display("[TB] reset and idle");
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 4'b0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 0, 4'b0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 4'b0000, 1'b0, 1'b0);
      idle(20);

      $display("[TB] add 60 then three ticks");
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 4'b0001, 1'b0, 1'b0);
      for (int t = 0; t < 3; t++) begin
         idle(4);
         applyStimulus(1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0, 1'b0);
      end
      idle(20);

      $display("[TB] saturate meter 1");
      for (int n = 0; n < 34; n++) applyStimulus(1'b0, 1'b0, 1'b0, 1, 4'b1000, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1, 4'b0001, 1'b0, 1'b0);
      idle(20);

      $display("[TB] load_a with tick, then multi-bit add");
      for (int n = 0; n < 16; n++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 4'b1000, 1'b0, 1'b0);
      idle(18);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 4'b0110, 1'b0, 1'b0);
      idle(20);

      $display("[TB] count down to expiry and blink");
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 4'b0000, 1'b1, 1'b0);
      for (int t = 0; t < 18; t++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b1, 0, 4'b0000, 1'b0, 1'b0);
      end
      idle(20);

      $display("[TB] back-to-back adds and reset mid-conversion");
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 4'b0001, 1'b0, 1'b0);
      idle(4);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 4'b0100, 1'b0, 1'b0);
      idle(40);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 4'b0010, 1'b0, 1'b0);
      idle(6);
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 4'b0000, 1'b0, 1'b0);
      idle(20);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 3000; n++) begin
         bit         r, t1, t2, la, lb;
         int         s;
         logic [3:0] a;
         r  = ($urandom_range(0, 499) == 0);
         t1 = ($urandom_range(0, 9) == 0);
         t2 = ($urandom_range(0, 4) == 0);
         la = ($urandom_range(0, 39) == 0);
         lb = ($urandom_range(0, 39) == 0);
         a  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         s  = ($urandom_range(0, 63) == 0) ? (1 - curSel) : curSel;
         applyStimulus(r, t1, t2, s, a, la, lb);
      end
      idle(20);

      for (int w = 0; w < 5 && expQ.size() > 0; w++) @(negedge clk);
      if (expQ.size() > 0) begin
         totalCnt++;
         badCnt++;
         $display("[TB] FAIL drain: got=%0d pending want=0", expQ.size());
      end

      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule
